cmd_stream_router: RTL and testbench

CMD_STREAM_ROUTER -- requirements
Module: cmd_stream_router

---
 rtl/cmd_stream_pkg.sv | 42 ++++
 rtl/cmd_stream_router.sv | 201 ++++++++++++++++++++
 tb/tb_cmd_stream_router.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_stream_pkg.sv
// ---------------------------------------------------------------------------
// cmd_stream_pkg
//
// Shared definitions for the command stream router: opcode values, header
// field positions, FSM state encoding and destination indices.
//
// Header beat layout (low 32 bits only; anything above bit 31 is ignored):
//   [31:28]          opcode
//   [LEN_WIDTH-1:0]  payload length in beats
// ---------------------------------------------------------------------------
package cmd_stream_pkg;

    localparam int HDR_WIDTH  = 32;
    localparam int HDR_OP_MSB = 31;
    localparam int HDR_OP_LSB = 28;
    localparam int OP_WIDTH   = HDR_OP_MSB - HDR_OP_LSB + 1;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP        = 4'd0,
        OP_REG_WRITE  = 4'd1,
        OP_TEX_STREAM = 4'd2,
        OP_FB_SWAP    = 4'd3
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STREAM    = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_SWAP      = 3'd3,
        ST_SWAP_WAIT = 3'd4
    } state_t;

    // Payload destinations, used as bit positions of a one-hot select.
    localparam int NUM_DEST     = 2;
    localparam int DEST_REG_IDX = 0;
    localparam int DEST_TEX_IDX = 1;

    function automatic logic [OP_WIDTH-1:0] hdr_opcode(input logic [HDR_WIDTH-1:0] hdr);
        return hdr[HDR_OP_MSB:HDR_OP_LSB];
    endfunction

endpackage

// File: rtl/cmd_stream_router.sv
// ---------------------------------------------------------------------------
// cmd_stream_router
//
// Parses a command stream made of header beats followed by payload beats and
// routes payloads to either the register bank or the texture loader. Also
// issues framebuffer swap requests and flags illegal opcodes.
//
// Ports
//   aclk, resetn               clock, synchronous active-low reset
//   s_axis_*                   command input stream (tlast is ignored)
//   m_reg_axis_*               payload stream to the register bank
//   m_tex_axis_*               payload stream to the texture loader
//   fb_swap                    one-cycle framebuffer swap request
//   fb_busy                    framebuffer swap in progress
//   cmd_error                  sticky illegal-opcode flag
//
// Payload beats are passed through combinationally (zero latency), so the
// downstream stability guarantee comes directly from the upstream source
// holding tdata/tvalid while stalled.
// ---------------------------------------------------------------------------
module cmd_stream_router
    import cmd_stream_pkg::*;
#(
    parameter int CMD_STREAM_WIDTH = 32,
    parameter int LEN_WIDTH        = 16
) (
    input  logic                        aclk,
    input  logic                        resetn,

    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [CMD_STREAM_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tlast,

    output logic                        m_reg_axis_tvalid,
    input  logic                        m_reg_axis_tready,
    output logic                        m_reg_axis_tlast,
    output logic [CMD_STREAM_WIDTH-1:0] m_reg_axis_tdata,

    output logic                        m_tex_axis_tvalid,
    input  logic                        m_tex_axis_tready,
    output logic                        m_tex_axis_tlast,
    output logic [CMD_STREAM_WIDTH-1:0] m_tex_axis_tdata,

    output logic                        fb_swap,
    input  logic                        fb_busy,
    output logic                        cmd_error
);

    // Packet framing is carried by the header length, not by tlast.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                 state_reg;
    logic [LEN_WIDTH-1:0]   remaining_reg;
    logic [NUM_DEST-1:0]    dest_sel_reg;   // one-hot payload destination
    logic                   cmd_error_reg;
    logic                   fb_swap_reg;

    // ------------------------------------------------------------------
    // Header decode (only meaningful while in IDLE)
    // ------------------------------------------------------------------
    logic [OP_WIDTH-1:0]    hdr_op;
    logic [LEN_WIDTH-1:0]   hdr_len;
    logic                   hdr_len_zero;

    assign hdr_op       = hdr_opcode(s_axis_tdata[HDR_WIDTH-1:0]);
    assign hdr_len      = s_axis_tdata[LEN_WIDTH-1:0];
    assign hdr_len_zero = (hdr_len == '0);

    // ------------------------------------------------------------------
    // Combinational handshake / output muxing
    // ------------------------------------------------------------------
    logic [NUM_DEST-1:0]    dest_ready;
    logic [NUM_DEST-1:0]    dest_valid;
    logic [NUM_DEST-1:0]    dest_last;
    logic                   sel_ready;
    logic                   stream_active;
    logic                   last_beat;
    logic                   beat;

    assign dest_ready[DEST_REG_IDX] = m_reg_axis_tready;
    assign dest_ready[DEST_TEX_IDX] = m_tex_axis_tready;

    // Outputs are qualified with resetn so they are quiet for the whole
    // reset interval, including the cycles before the first clock edge.
    assign stream_active = resetn && (state_reg == ST_STREAM);
    assign last_beat     = (remaining_reg == LEN_WIDTH'(1));
    assign sel_ready     = |(dest_sel_reg & dest_ready);

    generate
        for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_dest
            logic sel;
            assign sel            = stream_active && dest_sel_reg[gi];
            assign dest_valid[gi] = sel && s_axis_tvalid;
            assign dest_last[gi]  = sel && last_beat;
        end
    endgenerate

    always_comb begin
        s_axis_tready = 1'b0;
        if (resetn) begin
            case (state_reg)
                ST_IDLE:   s_axis_tready = 1'b1;
                ST_DRAIN:  s_axis_tready = 1'b1;
                ST_STREAM: s_axis_tready = sel_ready;
                default:   s_axis_tready = 1'b0;
            endcase
        end
    end

    assign beat = s_axis_tvalid && s_axis_tready;

    assign m_reg_axis_tvalid = dest_valid[DEST_REG_IDX];
    assign m_reg_axis_tlast  = dest_last[DEST_REG_IDX];
    assign m_reg_axis_tdata  = s_axis_tdata;

    assign m_tex_axis_tvalid = dest_valid[DEST_TEX_IDX];
    assign m_tex_axis_tlast  = dest_last[DEST_TEX_IDX];
    assign m_tex_axis_tdata  = s_axis_tdata;

    assign fb_swap   = resetn && fb_swap_reg;
    assign cmd_error = resetn && cmd_error_reg;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            dest_sel_reg  <= '0;
            cmd_error_reg <= 1'b0;
            fb_swap_reg   <= 1'b0;
        end else begin
            fb_swap_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        case (hdr_op)
                            OP_NOP: begin
                                // header consumed, nothing else to do
                            end
                            OP_REG_WRITE, OP_TEX_STREAM: begin
                                // Zero-length payloads are consumed as bare headers.
                                if (!hdr_len_zero) begin
                                    state_reg                  <= ST_STREAM;
                                    remaining_reg              <= hdr_len;
                                    dest_sel_reg[DEST_REG_IDX] <= (hdr_op == OP_REG_WRITE);
                                    dest_sel_reg[DEST_TEX_IDX] <= (hdr_op == OP_TEX_STREAM);
                                end
                            end
                            OP_FB_SWAP: begin
                                // Pulse is issued in the same cycle the FSM sits in SWAP.
                                state_reg   <= ST_SWAP;
                                fb_swap_reg <= 1'b1;
                            end
                            default: begin
                                // Unknown opcode: flag it and throw away its payload
                                // so the stream stays framed.
                                cmd_error_reg <= 1'b1;
                                if (!hdr_len_zero) begin
                                    state_reg     <= ST_DRAIN;
                                    remaining_reg <= hdr_len;
                                end
                            end
                        endcase
                    end
                end

                ST_STREAM, ST_DRAIN: begin
                    // remaining is >= 1 in these states, so it cannot wrap.
                    if (beat) begin
                        remaining_reg <= remaining_reg - LEN_WIDTH'(1);
                        if (last_beat) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end

                ST_SWAP: begin
                    state_reg <= ST_SWAP_WAIT;
                end

                ST_SWAP_WAIT: begin
                    if (!fb_busy) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_stream_router.sv
// ---------------------------------------------------------------------------
// tb_cmd_stream_router
//
// Directed bench for cmd_stream_router. A 64-bit stream is used so that the
// header bits above 31 carry junk that must be ignored. Inputs change 1 time
// unit after the rising edge; outputs are checked 3 time units after it.
// ---------------------------------------------------------------------------
module tb_cmd_stream_router;

    localparam int W  = 64;
    localparam int LW = 16;

    logic          aclk = 1'b0;
    logic          resetn;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tlast;
    logic          m_reg_axis_tvalid;
    logic          m_reg_axis_tready;
    logic          m_reg_axis_tlast;
    logic [W-1:0]  m_reg_axis_tdata;
    logic          m_tex_axis_tvalid;
    logic          m_tex_axis_tready;
    logic          m_tex_axis_tlast;
    logic [W-1:0]  m_tex_axis_tdata;
    logic          fb_swap;
    logic          fb_busy;
    logic          cmd_error;

    int tests_run    = 0;
    int tests_failed = 0;
    int swap_pulses  = 0;

    always #5 aclk = ~aclk;

    cmd_stream_router #(
        .CMD_STREAM_WIDTH (W),
        .LEN_WIDTH        (LW)
    ) dut (
        .aclk              (aclk),
        .resetn            (resetn),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tlast      (s_axis_tlast),
        .m_reg_axis_tvalid (m_reg_axis_tvalid),
        .m_reg_axis_tready (m_reg_axis_tready),
        .m_reg_axis_tlast  (m_reg_axis_tlast),
        .m_reg_axis_tdata  (m_reg_axis_tdata),
        .m_tex_axis_tvalid (m_tex_axis_tvalid),
        .m_tex_axis_tready (m_tex_axis_tready),
        .m_tex_axis_tlast  (m_tex_axis_tlast),
        .m_tex_axis_tdata  (m_tex_axis_tdata),
        .fb_swap           (fb_swap),
        .fb_busy           (fb_busy),
        .cmd_error         (cmd_error)
    );

    // fb_swap is a registered output, so it is stable at the falling edge.
    always @(negedge aclk) begin
        if (fb_swap) swap_pulses++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Header with junk in bits 63:32 and 27:16, which must be ignored.
    function automatic logic [63:0] hdr(input logic [3:0] op, input logic [15:0] len);
        return {32'hA5A5_5A5A, op, 12'h0F0, len};
    endfunction

    task automatic adv();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        #2;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn            = 1'b0;
        s_axis_tvalid     = 1'b0;
        s_axis_tdata      = '0;
        s_axis_tlast      = 1'b0;
        m_reg_axis_tready = 1'b1;
        m_tex_axis_tready = 1'b1;
        fb_busy           = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) adv();
        drive(1'b1, hdr(4'd1, 16'd3));
        check_eq("rst_s_tready",  s_axis_tready,     1'b0);
        check_eq("rst_reg_valid", m_reg_axis_tvalid, 1'b0);
        check_eq("rst_tex_valid", m_tex_axis_tvalid, 1'b0);
        check_eq("rst_reg_last",  m_reg_axis_tlast,  1'b0);
        check_eq("rst_tex_last",  m_tex_axis_tlast,  1'b0);
        check_eq("rst_fb_swap",   fb_swap,           1'b0);
        check_eq("rst_cmd_error", cmd_error,         1'b0);
        adv();

        // ---------------- REG_WRITE len=0 then NOP ----------------
        resetn = 1'b1;
        drive(1'b1, hdr(4'd1, 16'd0));
        check_eq("first_hdr_ready", s_axis_tready,     1'b1);
        check_eq("len0_reg_valid",  m_reg_axis_tvalid, 1'b0);
        adv();
        drive(1'b1, hdr(4'd0, 16'd5));
        check_eq("nop_ready",       s_axis_tready,     1'b1);
        check_eq("nop_reg_valid",   m_reg_axis_tvalid, 1'b0);
        check_eq("nop_tex_valid",   m_tex_axis_tvalid, 1'b0);
        adv();
        drive(1'b0, '0);
        check_eq("post_nop_ready",  s_axis_tready,     1'b1);
        check_eq("post_nop_valid",  m_reg_axis_tvalid, 1'b0);
        adv();

        // ---------------- REG_WRITE len=3 ----------------
        drive(1'b1, hdr(4'd1, 16'd3));
        check_eq("reg3_hdr_ready", s_axis_tready,     1'b1);
        check_eq("reg3_hdr_valid", m_reg_axis_tvalid, 1'b0);
        adv();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'hCAFE_0000_1111_0000 + 64'(i));
            check_eq($sformatf("reg3_b%0d_valid", i), m_reg_axis_tvalid, 1'b1);
            check_eq($sformatf("reg3_b%0d_data", i),  m_reg_axis_tdata,  64'hCAFE_0000_1111_0000 + 64'(i));
            check_eq($sformatf("reg3_b%0d_last", i),  m_reg_axis_tlast,  (i == 2) ? 1'b1 : 1'b0);
            check_eq($sformatf("reg3_b%0d_tex", i),   m_tex_axis_tvalid, 1'b0);
            check_eq($sformatf("reg3_b%0d_ready", i), s_axis_tready,     1'b1);
            adv();
        end

        // ---------------- TEX_STREAM len=2, back-to-back header ----------------
        drive(1'b1, hdr(4'd2, 16'd2));
        check_eq("tex2_hdr_ready", s_axis_tready, 1'b1);
        adv();
        m_tex_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h7E70_0000_0000_00A0);
            check_eq($sformatf("tex2_stall%0d_ready", i), s_axis_tready,     1'b0);
            check_eq($sformatf("tex2_stall%0d_valid", i), m_tex_axis_tvalid, 1'b1);
            check_eq($sformatf("tex2_stall%0d_data", i),  m_tex_axis_tdata,  64'h7E70_0000_0000_00A0);
            check_eq($sformatf("tex2_stall%0d_last", i),  m_tex_axis_tlast,  1'b0);
            check_eq($sformatf("tex2_stall%0d_reg", i),   m_reg_axis_tvalid, 1'b0);
            adv();
        end
        m_tex_axis_tready = 1'b1;
        drive(1'b1, 64'h7E70_0000_0000_00A0);
        check_eq("tex2_b0_ready", s_axis_tready,    1'b1);
        check_eq("tex2_b0_data",  m_tex_axis_tdata, 64'h7E70_0000_0000_00A0);
        check_eq("tex2_b0_last",  m_tex_axis_tlast, 1'b0);
        adv();
        drive(1'b1, 64'h7E70_0000_0000_00A1);
        check_eq("tex2_b1_valid", m_tex_axis_tvalid, 1'b1);
        check_eq("tex2_b1_data",  m_tex_axis_tdata,  64'h7E70_0000_0000_00A1);
        check_eq("tex2_b1_last",  m_tex_axis_tlast,  1'b1);
        adv();

        // ---------------- FB_SWAP with fb_busy high for 5 cycles ----------------
        drive(1'b1, hdr(4'd3, 16'd0));
        check_eq("swap_hdr_ready", s_axis_tready, 1'b1);
        adv();
        fb_busy = 1'b1;
        drive(1'b1, hdr(4'd1, 16'd1));
        check_eq("swap_pulse",       fb_swap,       1'b1);
        check_eq("swap_pulse_ready", s_axis_tready, 1'b0);
        adv();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, hdr(4'd1, 16'd1));
            check_eq($sformatf("swap_wait%0d_pulse", i), fb_swap,       1'b0);
            check_eq($sformatf("swap_wait%0d_ready", i), s_axis_tready, 1'b0);
            adv();
        end
        fb_busy = 1'b0;
        drive(1'b1, hdr(4'd1, 16'd1));
        check_eq("swap_release_ready", s_axis_tready, 1'b0);
        adv();
        drive(1'b1, hdr(4'd1, 16'd1));
        check_eq("swap_next_hdr_ready", s_axis_tready,     1'b1);
        check_eq("swap_next_hdr_valid", m_reg_axis_tvalid, 1'b0);
        adv();
        drive(1'b1, 64'h0000_0000_0000_BEEF);
        check_eq("swap_next_valid", m_reg_axis_tvalid, 1'b1);
        check_eq("swap_next_last",  m_reg_axis_tlast,  1'b1);
        adv();
        check_eq("swap_pulse_count", 64'(swap_pulses), 64'd1);

        // ---------------- illegal opcode 7 len=2, then REG_WRITE len=1 ----------------
        drive(1'b1, hdr(4'd7, 16'd2));
        check_eq("ill_hdr_err",   cmd_error,     1'b0);
        check_eq("ill_hdr_ready", s_axis_tready, 1'b1);
        adv();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'hD00D_0000_0000_0000 + 64'(i));
            check_eq($sformatf("drain%0d_err", i),   cmd_error,         1'b1);
            check_eq($sformatf("drain%0d_ready", i), s_axis_tready,     1'b1);
            check_eq($sformatf("drain%0d_reg", i),   m_reg_axis_tvalid, 1'b0);
            check_eq($sformatf("drain%0d_tex", i),   m_tex_axis_tvalid, 1'b0);
            adv();
        end
        drive(1'b1, hdr(4'd1, 16'd1));
        check_eq("ill_next_hdr_valid", m_reg_axis_tvalid, 1'b0);
        adv();
        drive(1'b1, 64'h0000_0000_0000_1234);
        check_eq("ill_next_valid", m_reg_axis_tvalid, 1'b1);
        check_eq("ill_next_data",  m_reg_axis_tdata,  64'h0000_0000_0000_1234);
        check_eq("ill_next_last",  m_reg_axis_tlast,  1'b1);
        check_eq("ill_err_sticky", cmd_error,         1'b1);
        adv();
        // illegal opcode with len=0 stays in IDLE
        drive(1'b1, hdr(4'hF, 16'd0));
        adv();
        drive(1'b0, '0);
        check_eq("ill_len0_ready", s_axis_tready, 1'b1);
        adv();

        // ---------------- reset mid-packet ----------------
        drive(1'b1, hdr(4'd1, 16'd4));
        adv();
        drive(1'b1, 64'h0000_0000_0000_AB01);
        check_eq("abort_b0_valid", m_reg_axis_tvalid, 1'b1);
        check_eq("abort_b0_last",  m_reg_axis_tlast,  1'b0);
        adv();
        resetn = 1'b0;
        drive(1'b1, 64'h0000_0000_0000_AB02);
        check_eq("abort_rst_valid", m_reg_axis_tvalid, 1'b0);
        check_eq("abort_rst_last",  m_reg_axis_tlast,  1'b0);
        check_eq("abort_rst_ready", s_axis_tready,     1'b0);
        check_eq("abort_rst_err",   cmd_error,         1'b0);
        adv();
        drive(1'b1, 64'h0000_0000_0000_AB03);
        check_eq("abort_rst2_err",  cmd_error,        1'b0);
        check_eq("abort_rst2_last", m_reg_axis_tlast, 1'b0);
        adv();
        resetn = 1'b1;
        drive(1'b1, hdr(4'd1, 16'd1));
        check_eq("abort_new_hdr_ready", s_axis_tready,     1'b1);
        check_eq("abort_new_hdr_valid", m_reg_axis_tvalid, 1'b0);
        adv();
        drive(1'b1, 64'h0000_0000_0000_C0DE);
        check_eq("abort_new_valid", m_reg_axis_tvalid, 1'b1);
        check_eq("abort_new_data",  m_reg_axis_tdata,  64'h0000_0000_0000_C0DE);
        check_eq("abort_new_last",  m_reg_axis_tlast,  1'b1);
        check_eq("abort_new_tex",   m_tex_axis_tvalid, 1'b0);
        adv();
        drive(1'b0, '0);
        check_eq("final_idle_ready", s_axis_tready,     1'b1);
        check_eq("final_idle_valid", m_reg_axis_tvalid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
